// File: rtl/aes_inv_mixcolumns_wddl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : aes_inv_mixcolumns_wddl                                          |
// | Brief   : Sequential dual-rail (WDDL) AES InvMixColumns, one column per    |
// |           evaluate phase with optional precharge phase between columns.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module aes_inv_mixcolumns_wddl #(
    parameter int NCOL      = 4,
    parameter bit PRECHARGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] sa_in,
    input  logic [127:0] sa_in_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] sa_out,
    output logic [127:0] sa_out_n,
    output logic         rail_err
);

    localparam logic [1:0] c_s_idle     = 2'd0;
    localparam logic [1:0] c_s_pre      = 2'd1;
    localparam logic [1:0] c_s_eval     = 2'd2;
    localparam logic [1:0] c_s_done     = 2'd3;
    localparam logic [1:0] c_last_col   = 2'(NCOL - 1);
    localparam logic [1:0] c_after_eval = PRECHARGE ? c_s_pre : c_s_eval;

    logic [1:0]   r_fsm;
    logic [1:0]   r_col;
    logic [127:0] r_sa;
    logic [127:0] r_sa_out;
    logic [127:0] r_sa_out_n;
    logic         r_out_valid;
    logic         r_in_ready;
    logic         r_rail_err;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_res;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of x4/x2/x1 join x8: 9, b, d and e all contain x8
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction

    always_comb begin
        w_col_in = r_sa[127:96];
        case (r_col)
            2'd0:    w_col_in = r_sa[127:96];
            2'd1:    w_col_in = r_sa[95:64];
            2'd2:    w_col_in = r_sa[63:32];
            default: w_col_in = r_sa[31:0];
        endcase
    end

    assign w_col_res = inv_mix_col(w_col_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= c_s_idle;
            r_col       <= 2'd0;
            r_sa        <= '0;
            r_sa_out    <= '0;
            r_sa_out_n  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_rail_err  <= 1'b0;
        end else begin
            case (r_fsm)
                c_s_idle: begin
                    if (in_valid) begin
                        r_sa       <= sa_in;
                        r_rail_err <= ~&(sa_in ^ sa_in_n);
                        r_col      <= 2'd0;
                        r_sa_out   <= '0;
                        r_sa_out_n <= '0;
                        r_in_ready <= 1'b0;
                        r_fsm      <= c_after_eval;
                    end
                end
                c_s_pre: begin
                    r_fsm <= c_s_eval;
                end
                c_s_eval: begin
                    // Only the active column leaves 0/0; the rest keep their value
                    case (r_col)
                        2'd0: begin
                            r_sa_out[127:96]   <= w_col_res;
                            r_sa_out_n[127:96] <= ~w_col_res;
                        end
                        2'd1: begin
                            r_sa_out[95:64]    <= w_col_res;
                            r_sa_out_n[95:64]  <= ~w_col_res;
                        end
                        2'd2: begin
                            r_sa_out[63:32]    <= w_col_res;
                            r_sa_out_n[63:32]  <= ~w_col_res;
                        end
                        default: begin
                            r_sa_out[31:0]     <= w_col_res;
                            r_sa_out_n[31:0]   <= ~w_col_res;
                        end
                    endcase
                    if (r_col == c_last_col) begin
                        r_out_valid <= 1'b1;
                        r_fsm       <= c_s_done;
                    end else begin
                        r_col <= r_col + 2'd1;
                        r_fsm <= c_after_eval;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= c_s_idle;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sa_out    = r_sa_out;
    assign sa_out_n  = r_sa_out_n;
    assign rail_err  = r_rail_err;

endmodule
`default_nettype wire

// File: doc/aes_inv_mixcolumns_wddl.md
Name: aes_inv_mixcolumns_wddl

Overview:
- Sequential inverse MixColumns for the WDDL (dual-rail) AES decryption datapath. It is the decrypt-direction counterpart of the combinational dual-rail MixColumns used in encryption.
- Accepts a full 128-bit state on both rails through a valid/ready handshake. Processes one 32-bit column per evaluate phase, with a mandatory precharge phase between columns.
- Returns the result on both rails. Sits between the dual-rail AddRoundKey output and the dual-rail InvShiftRows/InvSubBytes stage.

Parameters:
- NCOL, 4, number of columns processed per state; fixed at 4 for AES-128/192/256.
- PRECHARGE, 1, 1 = insert a precharge cycle before every column evaluate; 0 = evaluate back-to-back (debug/area builds only).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state present on sa_in / sa_in_n
- in_ready  output  1  block idle and able to capture a state
- sa_in  input  128  true rail of the input state; column c = bits [127-32c -: 32]; byte 0 of a column is its MSB byte
- sa_in_n  input  128  complement rail of the input state
- out_valid  output  1  sa_out / sa_out_n hold a complete result
- out_ready  input  1  downstream accepts the result
- sa_out  output  128  true rail of the result
- sa_out_n  output  128  complement rail of the result
- rail_err  output  1  sticky flag: a captured input had a non-complementary rail pair

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; in_ready=1, out_valid=0, rail_err=0.
  - sa_out=0 and sa_out_n=0 (precharge value); internal state registers cleared.
  - rst overrides every other input in the same cycle, including mid-operation. Any partial result is discarded; no out_valid is produced for it.
- FSM states: IDLE, PRE, EVAL, DONE. A 2-bit column counter col runs 0..3.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture sa_in and sa_in_n, set col=0, clear sa_out/sa_out_n to all zeros, go to PRE (or EVAL when PRECHARGE=0).
  - rail_err is loaded with (~&(sa_in ^ sa_in_n)) at capture and holds until the next capture or reset.
  - The datapath always uses the true rail of the captured state.
- PRE (one cycle):
  - The column-result dual-rail register is driven to 0/0.
  - No output bits change. Go to EVAL.
- EVAL (one cycle):
  - Compute column col: with inputs a0..a3,
    - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
    - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
    - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
    - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplication is over GF(2^8) mod 0x11b, built from chained xtime: 09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2.
  - Write sa_out[column col] = {b0,b1,b2,b3} and sa_out_n[column col] = ~{b0,b1,b2,b3}. Other columns are unchanged.
  - If col==3, go to DONE; else col++ and go to PRE.
- DONE:
  - out_valid=1, in_ready=0. sa_out/sa_out_n stay stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle and the FSM returns to IDLE. Outputs keep their value until the next capture.
  - No new state is captured in the same cycle as the DONE→IDLE handoff.
- Latency:
  - Capture edge T; out_valid high at T+9 when PRECHARGE=1, T+5 when PRECHARGE=0.
  - Throughput is one state per 10 cycles (PRECHARGE=1) with out_ready held high.
- Rail invariant: in DONE, sa_out ^ sa_out_n == all ones. Between capture and DONE, not-yet-evaluated columns read 0/0.
- in_valid outside IDLE is ignored; the input need not be held after capture.

Test Plan:
- Column 0 = 8e4da1bc, other columns 00000000, sa_in_n = ~sa_in -> out_valid at T+9; sa_out column0 = db135345, other columns 00000000, sa_out_n = ~sa_out, rail_err=0.
- State 9fdc589d_01010101_c6c6c6c6_8e4da1bc -> sa_out = f20a225c_01010101_c6c6c6c6_db135345.
- out_ready held low for 5 cycles in DONE -> out_valid and sa_out stable throughout; one cycle after out_ready=1, out_valid=0 and in_ready=1.
- sa_in_n bit 0 flipped (non-complementary) -> rail_err=1 from T+1; result still equals the true-rail computation; the next clean capture clears rail_err.
- rst asserted at T+4 (mid-EVAL) -> next cycle in IDLE with in_ready=1, out_valid=0, sa_out=sa_out_n=0; no stray out_valid follows.
- Probe sa_out/sa_out_n after each EVAL edge -> column k is complementary from its EVAL edge onward; columns >k read 0/0.
